audio_sample_sink: RTL and testbench

AUDIO_SAMPLE_SINK -- requirements
Module: audio_sample_sink

---
 rtl/audio_sample_sink.sv | 127 ++++++++++++
 tb/tb_audio_sample_sink.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_sink.sv
// rtl/audio_sample_sink.sv - sample-rate strobe generator with FWFT capture FIFO
module audio_sample_sink #(
    parameter int CLOCK_RATE  = 48000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              run,
    output logic                              audio_clk_en,
    input  logic signed [15:0]                sample_in,
    output logic signed [15:0]                sample_out,
    output logic                              sample_valid,
    input  logic                              sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow,
    input  logic                              clear_overflow
);

    // Accumulator width holds any value below CLOCK_RATE; the sum gets one
    // extra bit so acc + SAMPLE_RATE can never wrap before the compare.
    localparam int AW = $clog2(CLOCK_RATE) + 1;
    localparam int SW = AW + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [SW-1:0] SR   = SW'(SAMPLE_RATE);
    localparam logic [SW-1:0] CR   = SW'(CLOCK_RATE);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    logic [AW-1:0]        acc;
    logic [SW-1:0]        acc_sum;
    logic [AW-1:0]        acc_next;
    logic                 strobe_next;
    logic                 cap_pending;

    logic signed [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 fifo_full;
    logic                 write_req;
    logic                 pop;
    logic                 do_write;
    logic                 drop;

    // Phase accumulator step: wrap past CLOCK_RATE produces a strobe and
    // keeps the remainder, so the long-run rate is exact.
    always_comb begin
        acc_sum     = {1'b0, acc} + SR;
        acc_next    = acc_sum[AW-1:0];
        strobe_next = 1'b0;
        if (acc_sum >= CR) begin
            acc_next    = AW'(acc_sum - CR);
            strobe_next = 1'b1;
        end
    end

    // Accumulator, registered strobe and the capture-pending flag that marks
    // the cycle in which sample_in is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            audio_clk_en <= 1'b0;
            cap_pending  <= 1'b0;
        end else if (run) begin
            acc          <= acc_next;
            audio_clk_en <= strobe_next;
            cap_pending  <= audio_clk_en;
        end else begin
            acc          <= '0;
            audio_clk_en <= 1'b0;
            cap_pending  <= 1'b0;
        end
    end

    // FIFO control: a write into a full FIFO only lands if a pop frees the
    // slot on the same edge; otherwise the sample is dropped.
    always_comb begin
        fifo_full    = (fifo_level == FULL);
        sample_valid = (fifo_level != '0);
        pop          = sample_valid && sample_ready;
        write_req    = cap_pending && run;
        do_write     = write_req && (!fifo_full || pop);
        drop         = write_req && fifo_full && !pop;
        sample_out   = sample_valid ? mem[rd_ptr] : 16'sd0;
    end

    // Sample storage; contents need no reset because sample_out is gated by level.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_write && !pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop && !do_write) begin
                fifo_level <= fifo_level - LW'(1);
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_sample_sink.sv
// tb/tb_audio_sample_sink.sv - scoreboard bench for audio_sample_sink
module tb_audio_sample_sink;

    logic               clk;
    logic               reset;
    logic               run;
    logic               audio_clk_en;
    logic signed [15:0] sample_in;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               sample_ready;
    logic [3:0]         fifo_level;
    logic               overflow;
    logic               clear_overflow;

    int n_tests;
    int n_fail;
    int exp_q[$];
    int strobe_cnt;
    int keep_limit;
    int seq_base;
    int seq_step;

    audio_sample_sink #(
        .CLOCK_RATE (120000),
        .SAMPLE_RATE(48000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .audio_clk_en  (audio_clk_en),
        .sample_in     (sample_in),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Source model: on each strobe present the next ramp value; the first
    // keep_limit samples of a test are the ones expected to come out.
    always @(negedge clk) begin
        if (reset) begin
            strobe_cnt = 0;
            exp_q.delete();
        end else if (audio_clk_en) begin
            sample_in = 16'(seq_base + seq_step * strobe_cnt);
            if (strobe_cnt < keep_limit) exp_q.push_back(seq_base + seq_step * strobe_cnt);
            strobe_cnt++;
        end
    end

    // Monitor: every accepted output is compared with the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (!reset && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0d expected no pop at %0t", sample_out, $time);
            end else begin
                check("pop_data", int'(sample_out), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        run            = 1'b0;
        sample_ready   = 1'b0;
        clear_overflow = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (strobe_cnt >= target) break;
            tick();
        end
        check("strobe_timeout", int'(strobe_cnt >= target), 1);
    endtask

    task automatic drain();
        sample_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (exp_q.size() == 0 && !sample_valid) break;
        end
        sample_ready = 1'b0;
        check("drain_level", int'(fifo_level), 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] en_mask;
        logic [15:0] vld_mask;
        n_tests        = 0;
        n_fail         = 0;
        keep_limit     = 0;
        seq_base       = 0;
        seq_step       = 0;
        sample_in      = 16'sd0;
        run            = 1'b0;
        sample_ready   = 1'b0;
        clear_overflow = 1'b0;
        reset          = 1'b1;
        #1;
        check("rst_en", int'(audio_clk_en), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_out", int'(sample_out), 0);
        check("rst_ovf", int'(overflow), 0);

        // Strobe cadence 3,5,8,10,13,15 and 2-cycle capture-to-visible latency.
        do_reset();
        seq_base     = 100;
        seq_step     = 100;
        keep_limit   = 5;
        run          = 1'b1;
        sample_ready = 1'b1;
        en_mask      = 16'hA528;
        vld_mask     = 16'h94A0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check($sformatf("strobe_c%0d", k), int'(audio_clk_en), int'(en_mask[k]));
            check($sformatf("valid_c%0d", k), int'(sample_valid), int'(vld_mask[k]));
        end
        run = 1'b0;
        drain();

        // Overflow: 10 strobes with no reader keeps only the first 8.
        do_reset();
        seq_base   = -500;
        seq_step   = 100;
        keep_limit = 8;
        run        = 1'b1;
        wait_strobes(10, 60);
        tick();
        tick();
        tick();
        run = 1'b0;
        check("ovf_level", int'(fifo_level), 8);
        check("ovf_flag", int'(overflow), 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("ovf_cleared", int'(overflow), 0);
        drain();

        // Full FIFO with a pop on the capture cycle: both happen, no overflow.
        do_reset();
        seq_base   = 7;
        seq_step   = 11;
        keep_limit = 9;
        run        = 1'b1;
        wait_strobes(9, 60);
        tick();
        check("fullpop_pre_level", int'(fifo_level), 8);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        run          = 1'b0;
        check("fullpop_level", int'(fifo_level), 8);
        check("fullpop_ovf", int'(overflow), 0);
        drain();

        // Reset mid-operation with 5 buffered and one capture pending.
        do_reset();
        seq_base   = 1;
        seq_step   = 1;
        keep_limit = 0;
        run        = 1'b1;
        wait_strobes(6, 60);
        tick();
        check("midrst_pre_level", int'(fifo_level), 5);
        reset = 1'b1;
        #1;
        check("midrst_level", int'(fifo_level), 0);
        check("midrst_valid", int'(sample_valid), 0);
        check("midrst_out", int'(sample_out), 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("midrst_no_write", int'(fifo_level), 0);
        run = 1'b0;

        // run 1->0->1 mid-period: strobes stop, restart from acc=0, FIFO kept.
        do_reset();
        seq_base   = 1000;
        seq_step   = -300;
        keep_limit = 2;
        run        = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        check("toggle_level_a", int'(fifo_level), 2);
        run = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("toggle_off_c%0d", k), int'(audio_clk_en), 0);
        end
        check("toggle_level_b", int'(fifo_level), 2);
        keep_limit = 3;
        run        = 1'b1;
        en_mask    = 16'h0028;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("toggle_on_c%0d", k), int'(audio_clk_en), int'(en_mask[k]));
        end
        run = 1'b0;
        tick();
        tick();
        check("toggle_level_c", int'(fifo_level), 3);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
